// File: rtl/rcpu_bus_pkg.sv
// Shared constants for the RCPU memory bus unit: FSM encoding, default widths
// and beat-select values.
package rcpu_bus_pkg;

  localparam int DEFAULT_M              = 16;
  localparam int DEFAULT_N              = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LO   = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic BEAT_LO = 1'b0;
  localparam logic BEAT_HI = 1'b1;

endpackage

// File: rtl/rcpu_bus_timer.sv
// Per-beat ack watchdog: loadable down-counter that flags expiry on the last
// permitted wait cycle. Used only when RCPU_BUS_TIMEOUT_EN is defined.
module rcpu_bus_timer
  import rcpu_bus_pkg::*;
#(
  parameter int LIMIT = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic expire
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= W'(LIMIT);
    end else if (dec && count_reg != '0) begin
      count_reg <= count_reg - W'(1);
    end
  end

  // Fires during the LIMIT-th consecutive unacknowledged request cycle.
  assign expire = dec && (count_reg == W'(1));

endmodule

// File: rtl/rcpu_bus_unit.sv
// RCPU memory bus unit: splits core accesses into one or two M-bit req/ack beats
// and reassembles read data. Optional ack timeout under RCPU_BUS_TIMEOUT_EN.
module rcpu_bus_unit
  import rcpu_bus_pkg::*;
#(
  parameter int M              = DEFAULT_M,
  parameter int N              = DEFAULT_N,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           core_req,
  input  logic           core_we,
  input  logic           core_wide,
  input  logic [N-1:0]   core_addr,
  input  logic [2*M-1:0] core_wdata,
  output logic [2*M-1:0] core_rdata,
  output logic           core_done,
  output logic           core_err,
  output logic           core_busy,
  output logic [N-1:0]   mem_addr,
  output logic [M-1:0]   mem_wdata,
  output logic           mem_we,
  output logic           mem_req,
  input  logic           mem_ack,
  input  logic [M-1:0]   mem_rdata
);

  state_t         state_reg, state_next;
  logic [N-1:0]   addr_reg;
  logic           we_reg;
  logic           wide_reg;
  logic [2*M-1:0] wdata_reg;
  logic [2*M-1:0] rdata_reg;
  logic [M-1:0]   lo_reg;
  logic           beat_sel;
  logic           beat_ack;
  logic           abort;
  logic           start;

  assign start     = (state_reg == ST_IDLE) && core_req;
  assign mem_req   = (state_reg == ST_LO) || (state_reg == ST_HI);
  assign beat_sel  = (state_reg == ST_HI) ? BEAT_HI : BEAT_LO;
  assign beat_ack  = mem_req && mem_ack;
  assign mem_addr  = (beat_sel == BEAT_HI) ? addr_reg + N'(1) : addr_reg;
  assign mem_wdata = (beat_sel == BEAT_HI) ? wdata_reg[2*M-1:M] : wdata_reg[M-1:0];
  assign mem_we    = mem_req && we_reg;
  assign core_busy = (state_reg != ST_IDLE);
  assign core_done = (state_reg == ST_DONE);
  assign core_rdata = rdata_reg;

`ifdef RCPU_BUS_TIMEOUT_EN
  logic timer_load;
  logic timer_dec;
  logic err_reg;

  assign timer_load = start || beat_ack;
  assign timer_dec  = mem_req && !mem_ack;

  rcpu_bus_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .dec    (timer_dec),
    .expire (abort)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_reg <= 1'b0;
    end else if (state_reg == ST_IDLE) begin
      err_reg <= 1'b0;
    end else if (abort) begin
      err_reg <= 1'b1;
    end
  end

  assign core_err = err_reg && core_done;
`else
  assign abort    = 1'b0;
  assign core_err = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (core_req) state_next = ST_LO;
      ST_LO: begin
        if (mem_ack)    state_next = wide_reg ? ST_HI : ST_DONE;
        else if (abort) state_next = ST_DONE;
      end
      ST_HI: begin
        if (mem_ack || abort) state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // The low beat of a wide read is parked in lo_reg so core_rdata only changes
  // when the whole read has landed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_reg  <= '0;
      we_reg    <= 1'b0;
      wide_reg  <= 1'b0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      lo_reg    <= '0;
    end else begin
      if (start) begin
        addr_reg  <= core_addr;
        we_reg    <= core_we;
        wide_reg  <= core_wide;
        wdata_reg <= core_wdata;
      end
      if (beat_ack && !we_reg) begin
        if (beat_sel == BEAT_LO) begin
          if (wide_reg) lo_reg <= mem_rdata;
          else          rdata_reg <= {{M{1'b0}}, mem_rdata};
        end else begin
          rdata_reg <= {mem_rdata, lo_reg};
        end
      end else if (abort && !we_reg) begin
        rdata_reg <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rcpu_bus_unit.sv
// Directed, table-driven bench for rcpu_bus_unit with a cycle-accurate memory
// responder and hand-written reset / ignored-request / timeout sequences.
module tb_rcpu_bus_unit;

  logic        clk;
  logic        rst;
  logic        core_req;
  logic        core_we;
  logic        core_wide;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        core_done;
  logic        core_err;
  logic        core_busy;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        mem_req;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  int pass_cnt  = 0;
  int total_cnt = 0;

  rcpu_bus_unit #(
    .M              (16),
    .N              (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_wide  (core_wide),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .core_done  (core_done),
    .core_err   (core_err),
    .core_busy  (core_busy),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_req    (mem_req),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        wide;
    logic [31:0] addr;
    logic [31:0] hi_addr;
    logic [31:0] wdata;
    int          wait_lo;
    int          wait_hi;
    logic [15:0] rd_lo;
    logic [15:0] rd_hi;
    int          pulse_cyc;
    int          done_cyc;
    int          req_cycles;
    logic        err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];
  vec_t post_rst_vec;
  vec_t tmo_vec;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // Called at #1 after a rising edge with the unit idle; returns at the same phase
  // a few cycles after core_done.
  task automatic run_vec(input vec_t v, input string tag);
    int   cyc;
    int   beat;
    int   waitc;
    int   reqc;
    int   bad;
    int   extra_done;
    int   busy_late;
    bit   done_seen;
    logic [31:0] e_addr;
    logic [15:0] e_wdata;
    core_req   = 1'b1;
    core_we    = v.we;
    core_wide  = v.wide;
    core_addr  = v.addr;
    core_wdata = v.wdata;
    @(posedge clk); #1;
    core_req   = 1'b0;
    core_addr  = 32'hDEAD_BEEF;
    core_wdata = 32'h0BAD_F00D;
    cyc = 1; beat = 0; waitc = 0; reqc = 0; bad = 0; done_seen = 0;
    while (!done_seen && cyc < 60) begin
      core_req = (cyc == v.pulse_cyc);
      mem_ack  = 1'b0;
      if (mem_req) begin
        reqc++;
        e_addr  = (beat == 0) ? v.addr : v.hi_addr;
        e_wdata = (beat == 0) ? v.wdata[15:0] : v.wdata[31:16];
        if (beat > 1 || mem_addr !== e_addr || mem_we !== v.we ||
            (v.we && mem_wdata !== e_wdata)) bad++;
        if (waitc == ((beat == 0) ? v.wait_lo : v.wait_hi)) begin
          mem_ack   = 1'b1;
          mem_rdata = (beat == 0) ? v.rd_lo : v.rd_hi;
          check($sformatf("%s beat%0d_addr", tag, beat), mem_addr, e_addr);
          if (v.we) check($sformatf("%s beat%0d_wdata", tag, beat), mem_wdata, e_wdata);
          beat++;
          waitc = 0;
        end else begin
          waitc++;
        end
      end
      if (core_done) begin
        done_seen = 1;
        check({tag, " done_cycle"}, cyc, v.done_cyc);
        check({tag, " rdata"}, core_rdata, v.exp_rdata);
        check({tag, " err"}, core_err, v.err);
        check({tag, " req_cycles"}, reqc, v.req_cycles);
      end
      @(posedge clk); #1;
      cyc++;
    end
    mem_ack  = 1'b0;
    core_req = 1'b0;
    check({tag, " done_seen"}, done_seen, 1'b1);
    check({tag, " beat_stable"}, bad, 0);
    extra_done = 0; busy_late = 0;
    repeat (3) begin
      if (core_done) extra_done++;
      if (core_busy) busy_late++;
      @(posedge clk); #1;
    end
    check({tag, " extra_done"}, extra_done, 0);
    check({tag, " busy_after"}, busy_late, 0);
    $display("%s: we=%0d wide=%0d addr=%h rdata=%h err=%0d done_cyc=%0d", tag, v.we, v.wide,
             v.addr, core_rdata, core_err, cyc - 1);
  endtask

  initial begin
    int busy_low;
    int err_seen;
    int done_cnt;
    int req_low;
    logic [31:0] held;

    //               we wide addr          hi_addr       wdata         wl wh rd_lo    rd_hi    pul dc rc err exp_rdata
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0000_0101, 32'h0,        0, 0, 16'hBEEF, 16'h0,    0, 2, 1, 1'b0, 32'h0000_BEEF};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_D000, 32'h0000_D001, 32'h1234_5678, 2, 2, 16'h0,    16'h0,    0, 7, 6, 1'b0, 32'h0000_BEEF};
    vecs[2] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0,        0, 0, 16'hAAAA, 16'h5555, 0, 3, 2, 1'b0, 32'h5555_AAAA};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_0300, 32'h0000_0301, 32'h0,        1, 1, 16'h0F0F, 16'hF0F0, 2, 5, 4, 1'b0, 32'hF0F0_0F0F};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0021, 32'hCAFE_7777, 1, 0, 16'h0,    16'h0,    0, 3, 2, 1'b0, 32'hF0F0_0F0F};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_0007, 32'h0000_0008, 32'h0,        3, 0, 16'h1234, 16'h0,    0, 5, 4, 1'b0, 32'h0000_1234};
    post_rst_vec = '{1'b0, 1'b0, 32'h0000_0444, 32'h0000_0445, 32'h0, 0, 0, 16'h4321, 16'h0, 0, 2, 1, 1'b0, 32'h0000_4321};
    tmo_vec      = '{1'b0, 1'b0, 32'h0000_0500, 32'h0000_0501, 32'h0, 1000, 0, 16'h9999, 16'h0, 0, 5, 4, 1'b1, 32'h0};

    rst = 1'b0; core_req = 1'b0; core_we = 1'b0; core_wide = 1'b0;
    core_addr = '0; core_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset mem_req", mem_req, 1'b0);
    check("reset core_busy", core_busy, 1'b0);
    check("reset core_done", core_done, 1'b0);
    check("reset core_err", core_err, 1'b0);
    check("reset core_rdata", core_rdata, 32'h0);
    check("reset mem_addr", mem_addr, 32'h0);
    check("reset mem_wdata", mem_wdata, 16'h0);
    check("reset mem_we", mem_we, 1'b0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Stray acks while idle must not start or complete anything.
    mem_ack = 1'b1; mem_rdata = 16'h7E57;
    done_cnt = 0; busy_low = 0;
    repeat (3) begin
      if (core_done) done_cnt++;
      if (core_busy || mem_req) busy_low++;
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    check("idle_ack done", done_cnt, 0);
    check("idle_ack busy", busy_low, 0);
    check("idle_ack rdata", core_rdata, 32'h0);
    $display("idle_ack: rdata=%h", core_rdata);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted in the middle of a wide read's HI beat.
    held = core_rdata;
    core_req = 1'b1; core_we = 1'b0; core_wide = 1'b1; core_addr = 32'h0000_0040;
    @(posedge clk); #1;
    core_req = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("rst_mid hi_req", mem_req, 1'b1);
    check("rst_mid hi_addr", mem_addr, 32'h0000_0041);
    check("rst_mid rdata_held", core_rdata, held);
    rst = 1'b0;
    #1;
    check("rst_mid mem_req", mem_req, 1'b0);
    check("rst_mid core_busy", core_busy, 1'b0);
    check("rst_mid core_rdata", core_rdata, 32'h0);
    $display("rst_mid: mem_req=%0d busy=%0d rdata=%h", mem_req, core_busy, core_rdata);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    run_vec(post_rst_vec, "post_rst");

`ifdef RCPU_BUS_TIMEOUT_EN
    run_vec(tmo_vec, "timeout");
`else
    core_req = 1'b1; core_we = 1'b0; core_wide = 1'b0; core_addr = tmo_vec.addr;
    @(posedge clk); #1;
    core_req = 1'b0;
    busy_low = 0; err_seen = 0; done_cnt = 0; req_low = 0;
    repeat (20) begin
      if (!core_busy) busy_low++;
      if (core_err) err_seen++;
      if (core_done) done_cnt++;
      if (!mem_req) req_low++;
      @(posedge clk); #1;
    end
    check("no_timeout busy_low", busy_low, 0);
    check("no_timeout err", err_seen, 0);
    check("no_timeout done", done_cnt, 0);
    check("no_timeout req_low", req_low, 0);
    check("no_timeout rdata", core_rdata, 32'h0000_4321);
    $display("no_timeout: busy held 20 cycles, err_cycles=%0d", err_seen);
    rst = 1'b0;
    #1;
    check("no_timeout rst_busy", core_busy, 1'b0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
